// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit with HI/LO, MADD accumulate and flush-aware issue
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXL = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW   = MAXL > 1 ? $clog2(MAXL) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               madd_q, madd_d, dz_q, dz_d;
  logic               sgn, neg_a, neg_b, accept, is_mt, is_div;
  logic [WIDTH-1:0]   abs_a, abs_b, dvs, uq, ur, quo, rem;
  logic [2*WIDTH-1:0] prod;
  assign sgn    = ~op[0];
  assign is_mt  = op[2] & op[1];
  assign is_div = ~op[2] & op[1];
  assign accept = start & ~flush;
  assign prod   = {{WIDTH{sgn & rs[WIDTH-1]}}, rs} * {{WIDTH{sgn & rt[WIDTH-1]}}, rt};
  // Signed divide via magnitudes so MIN / -1 wraps to MIN with a zero remainder
  assign neg_a  = sgn & rs[WIDTH-1];
  assign neg_b  = sgn & rt[WIDTH-1];
  assign abs_a  = neg_a ? -rs : rs;
  assign abs_b  = neg_b ? -rt : rt;
  assign dvs    = abs_b == '0 ? WIDTH'(1) : abs_b;
  assign uq     = abs_a / dvs;
  assign ur     = abs_a % dvs;
  assign quo    = (neg_a ^ neg_b) ? -uq : uq;
  assign rem    = neg_a ? -ur : ur;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    madd_d  = madd_q;
    dz_d    = dz_q;
    if (state_q == IDLE) begin
      if (accept && is_mt) begin
        hi_d = op[0] ? hi_q : rs;
        lo_d = op[0] ? rs : lo_q;
      end else if (accept) begin
        state_d = RUN;
        cnt_d   = is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        res_d   = is_div ? {rem, quo} : prod;
        madd_d  = op[2];
        dz_d    = is_div && rt == '0;
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      if (!dz_q) {hi_d, lo_d} = madd_q ? {hi_q, lo_q} + res_q : res_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      madd_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      madd_q  <= madd_d;
      dz_q    <= dz_d;
    end
  end
  assign busy = state_q == RUN;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
